aes_key_expansion: RTL and testbench

//  Iterative AES key schedule (FIPS-197 sec. 5.2), one 32-bit word per clock.

---
 rtl/aes_key_expansion_pkg.sv | 50 +++++
 rtl/aes_sub_word.sv | 17 +
 rtl/aes_key_expansion.sv | 139 +++++++++++++
 tb/tb_aes_key_expansion.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_key_expansion_pkg.sv
// AES key schedule shared definitions: widths, rcon, FSM states,
// S-box table, and the byte helpers used by the key expansion datapath.
package aes_key_expansion_pkg;

  localparam int NB     = 4;
  localparam int WORD_W = 32;

  localparam logic [7:0] AES_RCON_INIT = 8'h01;
  localparam logic [7:0] AES_POLY      = 8'h1b;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(
    input logic [7:0] b
  );
    return SBOX[b];
  endfunction

  // GF(2^8) multiply by x: next rcon value.
  function automatic logic [7:0] xtime(
    input logic [7:0] b
  );
    return {b[6:0], 1'b0} ^
           (b[7] ? AES_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four byte S-box lookups on a 32-bit word.
// Ports: i_word (32b in), o_word (32b substituted out), combinational.
module aes_sub_word
  import aes_key_expansion_pkg::*;
(
  input  logic [WORD_W-1:0] i_word,
  output logic [WORD_W-1:0] o_word
);

  always_comb begin
    o_word = {sbox(i_word[31:24]),
              sbox(i_word[23:16]),
              sbox(i_word[15:8]),
              sbox(i_word[7:0])};
  end

endmodule

// File: rtl/aes_key_expansion.sv
// Iterative AES key schedule, one 32-bit word per clock, AES-128/192/256.
// Ports: clk, reset (async active-low), start, key (32*NK),
//   ExpandedKeys (128*(NR+1), word 0 in MSBs), busy, keys_valid.
module aes_key_expansion
  import aes_key_expansion_pkg::*;
#(
  parameter int NK = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [32*NK-1:0]        key,
  output logic [128*(NR+1)-1:0]   ExpandedKeys,
  output logic                    busy,
  output logic                    keys_valid
);

  localparam int NW = NB * (NR + 1);
  localparam int IW = $clog2(NW + 1);

  localparam logic [IW-1:0] LAST = IW'(NW - 1);
  localparam logic [IW-1:0] NKI  = IW'(NK);
  localparam logic [3:0]    MODL = 4'(NK - 1);

  state_e r_state;
  state_e w_next;

  logic [WORD_W-1:0] r_w [NW];
  logic [IW-1:0]     r_idx;
  logic [3:0]        r_mod;
  logic [7:0]        r_rcon;
  logic              r_busy;
  logic              r_valid;

  logic              w_load;
  logic              w_step;
  logic              w_last;
  logic [WORD_W-1:0] w_prev;
  logic [WORD_W-1:0] w_back;
  logic [WORD_W-1:0] w_rot;
  logic [WORD_W-1:0] w_sin;
  logic [WORD_W-1:0] w_sout;
  logic [WORD_W-1:0] w_temp;
  logic [WORD_W-1:0] w_new;

  assign w_last = (r_idx == LAST);

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_next = S_RUN;
          w_load = 1'b1;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_next = S_DONE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  assign w_prev = r_w[r_idx - 1'b1];
  assign w_back = r_w[r_idx - NKI];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};

  // One S-box word serves both the RotWord and the AES-256 mid-key case.
  assign w_sin = (r_mod == 4'd0) ? w_rot : w_prev;

  aes_sub_word u_sub (
    .i_word (w_sin),
    .o_word (w_sout)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 4'd0) begin
      w_temp = w_sout ^ {r_rcon, 24'h0};
    end else if (NK > 6 && r_mod == 4'd4) begin
      w_temp = w_sout;
    end
    w_new = w_back ^ w_temp;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NW; i++) begin
        r_w[i] <= '0;
      end
      r_idx   <= '0;
      r_mod   <= '0;
      r_rcon  <= AES_RCON_INIT;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_busy  <= (w_next == S_RUN);
      r_valid <= (w_next == S_DONE);
      if (w_load) begin
        for (int i = 0; i < NK; i++) begin
          r_w[i] <= key[32*NK-1-32*i -: 32];
        end
        r_idx  <= NKI;
        r_mod  <= '0;
        r_rcon <= AES_RCON_INIT;
      end else if (w_step) begin
        r_w[r_idx] <= w_new;
        r_idx      <= r_idx + 1'b1;
        r_mod      <= (r_mod == MODL) ? 4'd0
                                      : r_mod + 4'd1;
        if (r_mod == 4'd0) begin
          r_rcon <= xtime(r_rcon);
        end
      end
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_out
    assign ExpandedKeys[128*(NR+1)-1-32*g -: 32] = r_w[g];
  end

  assign busy       = r_busy;
  assign keys_valid = r_valid;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Bench for aes_key_expansion: AES-128/192/256 instances checked
// against a GF(2^8)-arithmetic key schedule model every cycle.
module tb_aes_key_expansion;

  typedef logic [31:0] words_t [60];

  localparam logic [127:0] K128 =
    128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [191:0] K192 =
    192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] K256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic          clk;
  logic          rst_n;
  logic [2:0]    st;
  logic [127:0]  key0;
  logic [191:0]  key1;
  logic [255:0]  key2;
  logic [1407:0] ek0;
  logic [1663:0] ek1;
  logic [1919:0] ek2;
  logic [2:0]    busy;
  logic [2:0]    kv;

  int n_cmp;
  int n_bad;
  bit chk_on;
  int lat [3];

  logic [7:0] sb [256];

  bit     m_busy  [3];
  bit     m_valid [3];
  bit     m_zero  [3];
  int     m_cnt   [3];
  words_t pend    [3];

  aes_key_expansion #(.NK(4), .NR(10)) dut0 (
    .clk(clk), .reset(rst_n), .start(st[0]), .key(key0),
    .ExpandedKeys(ek0), .busy(busy[0]), .keys_valid(kv[0]));
  aes_key_expansion #(.NK(6), .NR(12)) dut1 (
    .clk(clk), .reset(rst_n), .start(st[1]), .key(key1),
    .ExpandedKeys(ek1), .busy(busy[1]), .keys_valid(kv[1]));
  aes_key_expansion #(.NK(8), .NR(14)) dut2 (
    .clk(clk), .reset(rst_n), .start(st[2]), .key(key2),
    .ExpandedKeys(ek2), .busy(busy[2]), .keys_valid(kv[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] gmul(
    input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(
    input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  function automatic int nk_of(input int k);
    return 4 + 2 * k;
  endfunction

  function automatic int nw_of(input int k);
    return 4 * (nk_of(k) + 7);
  endfunction

  // FIPS-197 key expansion straight from the definition.
  task automatic expand(input logic [255:0] kl, input int nk,
                        output words_t w);
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 60; i++) w[i] = 32'h0;
    for (int i = 0; i < nk; i++) w[i] = kl[255-32*i -: 32];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        rc = 8'h01;
        for (int m = 1; m < i / nk; m++) rc = gmul(rc, 8'h02);
        t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
      end else if (nk > 6 && i % nk == 4) begin
        t = subw(t);
      end
      w[i] = w[i-nk] ^ t;
    end
  endtask

  function automatic logic [255:0] key_l(input int k);
    case (k)
      0:       return {key0, 128'h0};
      1:       return {key1, 64'h0};
      default: return key2;
    endcase
  endfunction

  function automatic logic [1919:0] got_keys(input int k);
    case (k)
      0:       return {ek0, 512'h0};
      1:       return {ek1, 256'h0};
      default: return ek2;
    endcase
  endfunction

  function automatic logic [1919:0] pack_exp(input int k);
    logic [1919:0] v;
    v = '0;
    for (int i = 0; i < nw_of(k); i++) v[1919-32*i -: 32] = pend[k][i];
    return v;
  endfunction

  // Cycle-level expectation: start accepted when not busy, then a
  // fixed number of cycles until the full schedule is visible.
  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        m_busy[k]  = 1'b0;
        m_valid[k] = 1'b0;
        m_zero[k]  = 1'b1;
        m_cnt[k]   = 0;
      end else if (st[k] && !m_busy[k]) begin
        m_busy[k]  = 1'b1;
        m_valid[k] = 1'b0;
        m_zero[k]  = 1'b0;
        m_cnt[k]   = nw_of(k) - nk_of(k);
        expand(key_l(k), nk_of(k), pend[k]);
      end else if (m_busy[k]) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] == 0) begin
          m_busy[k]  = 1'b0;
          m_valid[k] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1919:0] g;
    logic [1919:0] e;
    int            wi;
    if (chk_on) begin
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (busy[k] !== m_busy[k]) begin
          n_bad++;
          $display("FAIL busy[%0d] @%0t: got %b expected %b",
                   k, $time, busy[k], m_busy[k]);
        end
        n_cmp++;
        if (kv[k] !== m_valid[k]) begin
          n_bad++;
          $display("FAIL keys_valid[%0d] @%0t: got %b expected %b",
                   k, $time, kv[k], m_valid[k]);
        end
        if (m_valid[k] || m_zero[k]) begin
          g = got_keys(k);
          e = m_zero[k] ? '0 : pack_exp(k);
          n_cmp++;
          if (g !== e) begin
            n_bad++;
            wi = 0;
            for (int i = 59; i >= 0; i--)
              if (g[1919-32*i -: 32] !== e[1919-32*i -: 32]) wi = i;
            $display("FAIL keys[%0d] @%0t word %0d: got %h expected %h",
                     k, $time, wi, g[1919-32*wi -: 32],
                     e[1919-32*wi -: 32]);
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [127:0] got,
                     input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input logic [2:0] mask);
    int       n;
    bit [2:0] seen;
    n    = 0;
    seen = 3'b000;
    for (int k = 0; k < 3; k++) lat[k] = -1;
    while ((seen & mask) != mask && n < 200) begin
      cyc(1);
      n++;
      for (int k = 0; k < 3; k++)
        if (mask[k] && !seen[k] && kv[k]) begin
          seen[k] = 1'b1;
          lat[k]  = n;
        end
    end
    if ((seen & mask) != mask) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_valid: timeout mask %b seen %b", mask, seen);
    end
  endtask

  task automatic rnd_keys();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    key0 = v[127:0];
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    key1 = v[191:0];
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    key2 = v;
  endtask

  initial begin
    words_t       w;
    logic [7:0]   inv;
    int           n;
    n_cmp  = 0;
    n_bad  = 0;
    chk_on = 1'b0;
    rst_n  = 1'b0;
    st     = 3'b000;
    key0   = '0;
    key1   = '0;
    key2   = '0;

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^
              rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end

    expand({K128, 128'h0}, 4, w);
    chk("model128_w4", {96'h0, w[4]}, {96'h0, 32'ha0fafe17});
    chk("model128_r10", {w[40], w[41], w[42], w[43]},
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    expand({K192, 64'h0}, 6, w);
    chk("model192_r12", {w[48], w[49], w[50], w[51]},
        128'he98ba06f448c773c8ecc720401002202);
    expand(K256, 8, w);
    chk("model256_r14", {w[56], w[57], w[58], w[59]},
        128'hfe4890d1e6188d0b046df344706c631e);
    expand(256'h0, 4, w);
    chk("model128_zero_r10", {w[40], w[41], w[42], w[43]},
        128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    repeat (3) @(posedge clk);
    #2;
    chk_on = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);

    key0 = K128;
    key1 = K192;
    key2 = K256;
    st   = 3'b111;
    cyc(1);
    st   = 3'b000;
    wait_valid(3'b111);
    chk("lat128", 128'(lat[0]), 128'd40);
    chk("lat192", 128'(lat[1]), 128'd46);
    chk("lat256", 128'(lat[2]), 128'd52);
    chk("dut128_w4", {96'h0, ek0[1407-128 -: 32]}, {96'h0, 32'ha0fafe17});
    chk("dut128_r10", ek0[127:0], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    chk("dut192_r12", ek1[127:0], 128'he98ba06f448c773c8ecc720401002202);
    chk("dut256_r14", ek2[127:0], 128'hfe4890d1e6188d0b046df344706c631e);

    key0  = K128;
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    cyc(9);
    rnd_keys();
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    rnd_keys();
    wait_valid(3'b001);
    chk("lat_ignored_start", 128'(lat[0] + 10), 128'd40);
    chk("r10_ignored_start", ek0[127:0],
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    rnd_keys();
    st = 3'b111;
    cyc(1);
    st = 3'b000;
    cyc(19);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    chk("reset_busy", {125'h0, busy}, 128'h0);
    chk("reset_kv", {125'h0, kv}, 128'h0);
    chk("reset_keys", ek0[1407:1280] | ek0[127:0], 128'h0);
    @(posedge clk);
    #2;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    key0  = K128;
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    wait_valid(3'b001);
    chk("lat_after_reset", 128'(lat[0]), 128'd40);
    chk("r10_after_reset", ek0[127:0],
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

    key0  = '0;
    st[0] = 1'b1;
    cyc(1);
    st[0] = 1'b0;
    chk("kv_drop_restart", {127'h0, kv[0]}, 128'h0);
    wait_valid(3'b001);
    chk("r10_zero_key", ek0[127:0],
        128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    for (int it = 0; it < 8; it++) begin
      rnd_keys();
      st = 3'($urandom_range(1, 7));
      cyc(1);
      st = 3'b000;
      repeat ($urandom_range(0, 50)) begin
        rnd_keys();
        if ($urandom_range(0, 3) == 0) st = 3'($urandom_range(1, 7));
        else st = 3'b000;
        cyc(1);
      end
      st = 3'b000;
      n  = 0;
      while (busy != 3'b000 && n < 300) begin
        cyc(1);
        n++;
      end
      if (busy != 3'b000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL idle_wait: timeout busy %b", busy);
      end
      cyc(2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
